// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops, iterative rotate and
// shift-add multiply, with valid/ready handshakes on both sides.
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] aluIn1,
   input  logic [WIDTH-1:0] aluIn2,
   input  logic             carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] aluOut,
   output logic             N,
   output logic             Z,
   output logic             C,
   output logic             V,
   output logic             busy
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW:0] CNT_ONE   = (SHW+1)'(1);
   localparam logic [SHW:0] CNT_WIDTH = (SHW+1)'(WIDTH);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_ADC = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_ORR = 3'b100;
   localparam logic [2:0] OP_EOR = 3'b101;
   localparam logic [2:0] OP_ROR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [SHW:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0] wa_q, wa_d;
   logic [WIDTH-1:0] wb_q, wb_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             mul_q, mul_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;

   logic [WIDTH-1:0] b_eff_s;
   logic             cin_s;
   logic [WIDTH:0]   sum_s;
   logic             ovf_s;
   logic [SHW-1:0]   ror_amt_s;
   logic [WIDTH-1:0] step_s;
   logic [WIDTH-1:0] rot_s;
   logic             wr_s;

   // Shared adder: SUB is A + ~B + 1, so overflow is uniform on the effective B.
   always_comb begin
      b_eff_s   = (op == OP_SUB) ? ~aluIn2 : aluIn2;
      cin_s     = (op == OP_SUB) ? 1'b1 : ((op == OP_ADC) ? carry : 1'b0);
      sum_s     = {1'b0, aluIn1} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin_s};
      ovf_s     = (aluIn1[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != aluIn1[WIDTH-1]);
      ror_amt_s = aluIn2[SHW-1:0];
      step_s    = acc_q + (wb_q[0] ? wa_q : {WIDTH{1'b0}});
      rot_s     = {wa_q[0], wa_q[WIDTH-1:1]};
   end

   // Next-state, datapath and flag update; wr_s marks the result-write cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wa_d    = wa_q;
      wb_d    = wb_q;
      acc_d   = acc_q;
      mul_d   = mul_q;
      res_d   = res_q;
      c_d     = c_q;
      v_d     = v_q;
      wr_s    = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               case (op)
                  OP_ADD, OP_ADC, OP_SUB: begin
                     res_d   = sum_s[WIDTH-1:0];
                     c_d     = sum_s[WIDTH];
                     v_d     = ovf_s;
                     wr_s    = 1'b1;
                     state_d = DONE;
                  end
                  OP_AND: begin
                     res_d   = aluIn1 & aluIn2;
                     wr_s    = 1'b1;
                     state_d = DONE;
                  end
                  OP_ORR: begin
                     res_d   = aluIn1 | aluIn2;
                     wr_s    = 1'b1;
                     state_d = DONE;
                  end
                  OP_EOR: begin
                     res_d   = aluIn1 ^ aluIn2;
                     wr_s    = 1'b1;
                     state_d = DONE;
                  end
                  OP_ROR: begin
                     if (ror_amt_s == {SHW{1'b0}}) begin
                        res_d   = aluIn1;
                        wr_s    = 1'b1;
                        state_d = DONE;
                     end else begin
                        wa_d    = aluIn1;
                        cnt_d   = {1'b0, ror_amt_s};
                        mul_d   = 1'b0;
                        state_d = EXEC;
                     end
                  end
                  OP_MUL: begin
                     wa_d    = aluIn1;
                     wb_d    = aluIn2;
                     acc_d   = {WIDTH{1'b0}};
                     cnt_d   = CNT_WIDTH;
                     mul_d   = 1'b1;
                     state_d = EXEC;
                  end
                  default: state_d = IDLE;
               endcase
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            cnt_d = cnt_q - CNT_ONE;
            if (mul_q) begin
               acc_d = step_s;
               wa_d  = {wa_q[WIDTH-2:0], 1'b0};
               wb_d  = {1'b0, wb_q[WIDTH-1:1]};
            end else begin
               wa_d  = rot_s;
            end
            if (cnt_q == CNT_ONE) begin
               res_d   = mul_q ? step_s : rot_s;
               c_d     = mul_q ? c_q : rot_s[WIDTH-1];
               wr_s    = 1'b1;
               state_d = DONE;
            end else begin
               state_d = EXEC;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (wr_s) begin
         n_d = res_d[WIDTH-1];
         z_d = (res_d == {WIDTH{1'b0}});
      end else begin
         n_d = n_q;
         z_d = z_q;
      end
   end

   // State, working registers, result and flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= {(SHW+1){1'b0}};
         wa_q    <= {WIDTH{1'b0}};
         wb_q    <= {WIDTH{1'b0}};
         acc_q   <= {WIDTH{1'b0}};
         mul_q   <= 1'b0;
         res_q   <= {WIDTH{1'b0}};
         n_q     <= 1'b0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wa_q    <= wa_d;
         wb_q    <= wb_d;
         acc_q   <= acc_d;
         mul_q   <= mul_d;
         res_q   <= res_d;
         n_q     <= n_d;
         z_q     <= z_d;
         c_q     <= c_d;
         v_q     <= v_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign aluOut    = res_q;
   assign N         = n_q;
   assign Z         = z_q;
   assign C         = c_q;
   assign V         = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32) using immediate assertions.
module tb_alu_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  op = 3'b000;
   logic [31:0] aluIn1 = 32'h0;
   logic [31:0] aluIn2 = 32'h0;
   logic        carry = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] aluOut;
   logic        N, Z, C, V;
   logic        busy;

   int n_assert = 0;
   int n_fail   = 0;

   alu_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .aluIn1(aluIn1), .aluIn2(aluIn2), .carry(carry),
      .out_valid(out_valid), .out_ready(out_ready), .aluOut(aluOut),
      .N(N), .Z(Z), .C(C), .V(V), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one op, wait for out_valid, check latency/result/flags, optionally complete handshake.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic cin, input logic [31:0] exp_res,
                         input logic [3:0] exp_nzcv, input int exp_lat, input bit complete);
      int lat;
      @(negedge clk);
      check({tag, "/in_ready"}, {63'b0, in_ready}, 64'd1);
      in_valid = 1'b1; op = o; aluIn1 = a; aluIn2 = b; carry = cin;
      @(posedge clk); #1;
      in_valid = 1'b0; aluIn1 = 32'hDEAD_BEEF; aluIn2 = 32'h1234_5677; carry = ~cin; op = 3'b011;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "/result"}, {32'b0, aluOut}, {32'b0, exp_res});
      check({tag, "/nzcv"}, {60'b0, N, Z, C, V}, {60'b0, exp_nzcv});
      if (complete) begin
         @(negedge clk);
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         check({tag, "/in_ready_after"}, {63'b0, in_ready}, 64'd1);
         check({tag, "/out_valid_after"}, {63'b0, out_valid}, 64'd0);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] held;
      // Power-on reset
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst/aluOut", {32'b0, aluOut}, 64'd0);
      check("rst/nzcv", {60'b0, N, Z, C, V}, 64'd0);
      check("rst/out_valid", {63'b0, out_valid}, 64'd0);
      check("rst/in_ready", {63'b0, in_ready}, 64'd1);
      check("rst/busy", {63'b0, busy}, 64'd0);

      run_op("add_ovf", 3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b1001, 1, 1'b1);
      run_op("adc_wrap", 3'b001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0110, 1, 1'b1);
      run_op("sub_eq", 3'b010, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 4'b0110, 1, 1'b1);
      run_op("sub_borrow", 3'b010, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 4'b1000, 1, 1'b1);
      run_op("and_zero", 3'b011, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1, 32'h0000_0000, 4'b0100, 1, 1'b1);
      run_op("ror4", 3'b110, 32'h0000_0001, 32'h0000_0004, 1'b0, 32'h1000_0000, 4'b0000, 5, 1'b1);
      run_op("ror1", 3'b110, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b1010, 2, 1'b1);
      run_op("ror0", 3'b110, 32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0000_0001, 4'b0010, 1, 1'b1);
      run_op("mul", 3'b111, 32'h0000_FFFF, 32'h0001_0001, 1'b0, 32'hFFFF_FFFF, 4'b1010, 33, 1'b1);
      run_op("ror_hibits", 3'b110, 32'h8000_0001, 32'h0000_0021, 1'b0, 32'hC000_0000, 4'b1010, 2, 1'b1);
      run_op("sub_ovf", 3'b010, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 4'b0011, 1, 1'b1);
      run_op("add_carry", 3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'h0000_0001, 4'b0010, 1, 1'b1);

      // Backpressure: hold result in DONE while in_valid toggles
      run_op("orr_bp", 3'b100, 32'h1234_0000, 32'h0000_5678, 1'b0, 32'h1234_5678, 4'b0010, 1, 1'b0);
      held = 32'h1234_5678;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = i[0]; op = 3'b000; aluIn1 = 32'(i); aluIn2 = 32'h1;
         @(posedge clk); #1;
         check("bp/aluOut", {32'b0, aluOut}, {32'b0, held});
         check("bp/nzcv", {60'b0, N, Z, C, V}, 64'b0010);
         check("bp/in_ready", {63'b0, in_ready}, 64'd0);
         check("bp/out_valid", {63'b0, out_valid}, 64'd1);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp/in_ready_after", {63'b0, in_ready}, 64'd1);
      check("bp/out_valid_after", {63'b0, out_valid}, 64'd0);
      @(posedge clk); #1;
      check("bp/no_queued_op", {63'b0, busy}, 64'd0);
      check("bp/aluOut_kept", {32'b0, aluOut}, {32'b0, held});

      // MUL aborted by reset at cycle 10
      @(negedge clk);
      in_valid = 1'b1; op = 3'b111; aluIn1 = 32'h3; aluIn2 = 32'h5;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("abort/busy_before", {63'b0, busy}, 64'd1);
      check("abort/out_valid_before", {63'b0, out_valid}, 64'd0);
      rst_n = 1'b0;
      #1;
      check("abort/aluOut", {32'b0, aluOut}, 64'd0);
      check("abort/nzcv", {60'b0, N, Z, C, V}, 64'd0);
      check("abort/busy", {63'b0, busy}, 64'd0);
      check("abort/out_valid", {63'b0, out_valid}, 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("abort/in_ready_after", {63'b0, in_ready}, 64'd1);
      check("abort/out_valid_after", {63'b0, out_valid}, 64'd0);
      check("abort/aluOut_after", {32'b0, aluOut}, 64'd0);

      run_op("eor_post", 3'b101, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b0, 32'h5A5A_5A5A, 4'b0000, 1, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the team's combinational datapath ALU. Accepts one operation at a time over a valid/ready handshake, executes single-cycle arithmetic/logic ops and iterative rotate and multiply ops, and returns a registered result with registered N/Z/C/V flags over a second valid/ready handshake. Sits between the decode/issue stage and writeback; flags feed the condition-check logic.

## Interface
- WIDTH, 32, datapath width; legal values 8..64, power of two.
- SHW, log2(WIDTH), derived localparam; rotate-amount width.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept an operation
- op  in  3  operation select (see Operation)
- aluIn1  in  WIDTH  operand A
- aluIn2  in  WIDTH  operand B (rotate amount in ROR)
- carry  in  1  carry input, used by ADC only
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result
- aluOut  out  WIDTH  registered result
- N, Z, C, V  out  1 each  registered flags
- busy  out  1  high whenever state is not IDLE

## Operation
- Single clock domain; reset asynchronous, active-low.
- Operands, op and carry captured on the accept edge (in_valid && in_ready); inputs ignored afterwards.
- op: 000 ADD A+B; 001 ADC A+B+carry; 010 SUB A-B; 011 AND; 100 ORR; 101 EOR; 110 ROR A right by B[SHW-1:0]; 111 MUL, low WIDTH bits of A*B (unsigned).
- All arithmetic modulo 2^WIDTH; carry-out is bit WIDTH of the (WIDTH+1)-bit sum.
- Flags updated only on the cycle the result is written (entry to DONE):
  - N = aluOut[WIDTH-1]; Z = (aluOut == 0): all ops.
  - ADD/ADC: C = carry-out; V = (A[msb]==B[msb]) && (aluOut[msb]!=A[msb]).
  - SUB: computed as A + ~B + 1; C = carry-out (1 = no borrow); V = (A[msb]!=B[msb]) && (aluOut[msb]!=A[msb]).
  - AND/ORR/EOR/MUL: C and V unchanged.
  - ROR: C = aluOut[msb] if amount != 0, else unchanged; V unchanged.
- FSM states IDLE, EXEC, DONE:
  - IDLE: in_ready=1. On accept: ADD..EOR, or ROR with amount 0 -> DONE; ROR with amount k>0 -> EXEC, counter=k; MUL -> EXEC, counter=WIDTH.
  - EXEC: ROR rotates working register right by 1 per cycle; MUL performs one shift-add step per cycle (LSB of multiplier first). Counter decrements; on reaching 0, result and flags written, -> DONE.
  - DONE: out_valid=1; aluOut and flags held stable; on out_ready -> IDLE.
- in_ready low in EXEC and DONE; in_valid there is ignored (no queuing).
- Reset (any state, including mid-EXEC): state IDLE, aluOut=0, N=Z=C=V=0, out_valid=0, busy=0, in_ready=1 once reset deasserts; partial work discarded.

## Timing
- Latency, accept edge to out_valid high: 1 cycle for ADD..EOR and ROR amount 0; k+1 cycles for ROR amount k; WIDTH+1 cycles for MUL.
- Result handshake completes on the edge where out_valid && out_ready; in_ready high the following cycle.
- Maximum throughput: one single-cycle op every 2 cycles with out_ready held high.
- No combinational path from in_valid/operands to any output; in_ready, out_valid, busy decode from state register only.

## Test plan
- Reset: hold rst_n low 3 cycles mid-stimulus -> aluOut=0, flags 0, out_valid=0, in_ready=1 after release.
- ADD 0x7FFFFFFF + 0x00000001 -> aluOut=0x80000000, N=1 Z=0 C=0 V=1, out_valid 1 cycle after accept; ADC 0xFFFFFFFF+0+carry=1 -> 0, Z=1 C=1.
- SUB 5-5 -> 0, Z=1 C=1 V=0; SUB 0-1 -> 0xFFFFFFFF, N=1 C=0; then AND 0xF0F0F0F0 & 0x0F0F0F0F -> 0, Z=1, C stays 0.
- ROR 0x00000001 by 4 -> 0x10000000, C=0, out_valid 5 cycles after accept; by 1 -> 0x80000000, C=1; by 0 -> 0x00000001, latency 1, C unchanged.
- MUL 0x0000FFFF * 0x00010001 -> 0xFFFFFFFF, N=1 Z=0, out_valid 33 cycles after accept; assert rst_n low at cycle 10 of a second MUL -> abort, reset values.
- Backpressure: out_ready low 10 cycles in DONE with in_valid toggling -> aluOut/flags stable, in_ready=0, no new op accepted; out_ready high -> IDLE next cycle.
